// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter and the receiver:
//   parity_e       - parity mode encoding (NONE, ODD, EVEN)
//   tx_state_e     - transmitter frame states
//   cycles_per_bit - clock cycles per serial bit (truncating division)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts clock cycles inside one serial bit period and flags the last cycle.
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-high reset
//   i_restart   - hold the counter at zero (used while the line is idle)
//   o_bit_end   - high on the final cycle of the current bit period
//   o_count     - current cycle index within the bit, 0..CYCLES_PER_BIT-1
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 10,
    parameter int CNT_W          = (CYCLES_PER_BIT < 2) ? 1 : $clog2(CYCLES_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_restart,
    output logic             o_bit_end,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter: wraps at the end of every bit so timing never drifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_restart || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_bit_end = (r_count == LAST);
    assign o_count   = r_count;

endmodule

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
// UART transmitter: start bit, LSB-first payload, optional parity, 1 or 2 stop
// bits. One word is accepted per valid/ready handshake.
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous active-high reset
//   uart_tx_data   - word to send, sampled on the accept cycle only
//   uart_tx_en     - valid; accepted when high together with uart_tx_ready
//   uart_tx_ready  - high while idle
//   uart_tx_busy   - inverse of uart_tx_ready
//   uart_tx_done   - one-cycle pulse on the final cycle of the last stop bit
//   uart_txd       - serial line, idle high, driven from a flop
// -----------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_en,
    output logic                    uart_tx_ready,
    output logic                    uart_tx_busy,
    output logic                    uart_tx_done,
    output logic                    uart_txd
);

    import uart_pkg::parity_e;
    import uart_pkg::tx_state_e;
    import uart_pkg::NONE;
    import uart_pkg::ODD;
    import uart_pkg::EVEN;
    import uart_pkg::IDLE;
    import uart_pkg::START;
    import uart_pkg::DATA;
    import uart_pkg::STOP;
    import uart_pkg::cycles_per_bit;

    localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CNT_W = (CPB < 2) ? 1 : $clog2(CPB);
    localparam int BIT_W = $clog2(PAYLOAD_BITS);

    localparam parity_e          PAR_MODE  = parity_e'(PARITY);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CPB - 2);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    if (CPB < 2) begin : g_bad_rate
        $error("uart_frame_tx: CLK_HZ / BIT_RATE must be at least 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_frame_tx: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_frame_tx: STOP_BITS must be 1 or 2");
    end
    if ((PAYLOAD_BITS < 5) || (PAYLOAD_BITS > 9)) begin : g_bad_payload
        $error("uart_frame_tx: PAYLOAD_BITS must be 5..9");
    end

    tx_state_e               r_state;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_par;
    logic [BIT_W-1:0]        r_bit_idx;
    logic                    r_stop_idx;
    logic                    r_txd;
    logic                    r_done;

    logic                    w_restart;
    logic                    w_bit_end;
    logic [CNT_W-1:0]        w_count;
    logic                    w_par;
    logic [PAYLOAD_BITS-1:0] w_shift_next;

    // The timer sits at zero while idle so the start bit is a full period.
    assign w_restart    = (r_state == IDLE);
    assign w_shift_next = {1'b0, r_shift[PAYLOAD_BITS-1:1]};

    uart_bit_timer #(
        .CYCLES_PER_BIT (CPB),
        .CNT_W          (CNT_W)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_restart),
        .o_bit_end (w_bit_end),
        .o_count   (w_count)
    );

    // Parity of the word being accepted, latched alongside the data.
    always_comb begin
        case (PAR_MODE)
            ODD:     w_par = ~^uart_tx_data;
            EVEN:    w_par = ^uart_tx_data;
            default: w_par = 1'b0;
        endcase
    end

    // Frame sequencer; the line value is registered one bit ahead so uart_txd
    // changes exactly on the state/bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            // Done is set one cycle early so it is high on the last stop cycle.
            r_done <= (r_state == STOP) && (r_stop_idx == STOP_LAST) && (w_count == PRE_LAST);
            case (r_state)
                IDLE: begin
                    r_txd      <= 1'b1;
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    if (uart_tx_en) begin
                        r_shift <= uart_tx_data;
                        r_par   <= w_par;
                        r_txd   <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_txd   <= r_shift[0];
                        r_shift <= w_shift_next;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == BIT_LAST) begin
                            if (PAR_MODE != NONE) begin
                                r_txd   <= r_par;
                                r_state <= uart_pkg::PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                            r_txd     <= r_shift[0];
                            r_shift   <= w_shift_next;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (w_bit_end) begin
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == STOP_LAST) begin
                            r_state <= IDLE;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign uart_txd      = r_txd;
    assign uart_tx_done  = r_done;
    assign uart_tx_ready = (r_state == IDLE);
    assign uart_tx_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
// Three transmitters at CLK_HZ=1000, BIT_RATE=100 (10 cycles per bit):
//   dut 0: no parity, 1 stop; dut 1: even parity, 2 stop; dut 2: odd, 1 stop.
// Expected line values come from a frame model built from the frame rules.
// -----------------------------------------------------------------------------
module tb_uart_frame_tx;

    localparam int CPB  = 10;
    localparam int NDUT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NDUT-1:0] en;
    logic [7:0]      data [NDUT];
    wire  [NDUT-1:0] ready;
    wire  [NDUT-1:0] busy;
    wire  [NDUT-1:0] done;
    wire  [NDUT-1:0] txd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .uart_tx_data(data[0]), .uart_tx_en(en[0]),
        .uart_tx_ready(ready[0]), .uart_tx_busy(busy[0]), .uart_tx_done(done[0]), .uart_txd(txd[0]));

    uart_frame_tx #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset), .uart_tx_data(data[1]), .uart_tx_en(en[1]),
        .uart_tx_ready(ready[1]), .uart_tx_busy(busy[1]), .uart_tx_done(done[1]), .uart_txd(txd[1]));

    uart_frame_tx #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .reset(reset), .uart_tx_data(data[2]), .uart_tx_en(en[2]),
        .uart_tx_ready(ready[2]), .uart_tx_busy(busy[2]), .uart_tx_done(done[2]), .uart_txd(txd[2]));

    function automatic int par_of(input int k);
        case (k)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * CPB;
    endfunction

    // Line value of bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int par, input int idx);
        int ones;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if ((par != 0) && (idx == 9)) begin
            ones = $countones(d);
            if (par == 1) return ((ones % 2) == 0);
            return ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line must stay idle and ready for n cycles.
    task automatic check_idle(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_value($sformatf("idle_ready d%0d", k), 32'(ready[k]), 32'd1);
            check_value($sformatf("idle_busy d%0d", k), 32'(busy[k]), 32'd0);
            check_value($sformatf("idle_txd d%0d", k), 32'(txd[k]), 32'd1);
            check_value($sformatf("idle_done d%0d", k), 32'(done[k]), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Offer d, then follow the whole frame cycle by cycle. Called at posedge+1.
    task automatic send_frame(input int k, input logic [7:0] d, input bit hold_en,
                              input int inject_at, input int abort_at);
        int   len;
        logic eb;
        len     = frame_len(k);
        en[k]   = 1'b1;
        data[k] = d;
        @(negedge clk);
        check_value($sformatf("pre_ready d%0d", k), 32'(ready[k]), 32'd1);
        check_value($sformatf("pre_txd d%0d", k), 32'(txd[k]), 32'd1);
        check_value($sformatf("pre_done d%0d", k), 32'(done[k]), 32'd0);
        @(posedge clk); #1;
        if (!hold_en) en[k] = 1'b0;
        for (int c = 1; c <= len; c++) begin
            data[k] = 8'($urandom);
            eb = exp_bit(d, par_of(k), (c - 1) / CPB);
            if ((inject_at > 0) && (c == inject_at)) begin
                en[k]   = 1'b1;
                data[k] = 8'hFF;
            end
            if ((inject_at > 0) && (c == inject_at + 1)) en[k] = 1'b0;
            if (c == abort_at) begin
                check_value($sformatf("abort_pre_txd d%0d", k), 32'(txd[k]), 32'(eb));
                reset = 1'b1;
                #1;
                check_value($sformatf("abort_txd d%0d", k), 32'(txd[k]), 32'd1);
                check_value($sformatf("abort_ready d%0d", k), 32'(ready[k]), 32'd1);
                check_value($sformatf("abort_busy d%0d", k), 32'(busy[k]), 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                en[k] = 1'b0;
                return;
            end
            @(negedge clk);
            check_value($sformatf("txd d%0d c%0d", k, c), 32'(txd[k]), 32'(eb));
            check_value($sformatf("done d%0d c%0d", k, c), 32'(done[k]), 32'(c == len));
            check_value($sformatf("busy d%0d c%0d", k, c), 32'(busy[k]), 32'd1);
            check_value($sformatf("ready d%0d c%0d", k, c), 32'(ready[k]), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int k;
        int gap;
        reset = 1'b1;
        en    = '0;
        for (int i = 0; i < NDUT; i++) data[i] = 8'h00;
        #2;
        for (int i = 0; i < NDUT; i++) begin
            check_value($sformatf("rst_txd d%0d", i), 32'(txd[i]), 32'd1);
            check_value($sformatf("rst_ready d%0d", i), 32'(ready[i]), 32'd1);
            check_value($sformatf("rst_busy d%0d", i), 32'(busy[i]), 32'd0);
            check_value($sformatf("rst_done d%0d", i), 32'(done[i]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NDUT; i++) check_idle(i, 2);

        // Directed frames
        send_frame(0, 8'h55, 1'b0, 0, 0); check_idle(0, 2);
        send_frame(1, 8'h07, 1'b0, 0, 0); check_idle(1, 2);
        send_frame(2, 8'h07, 1'b0, 0, 0); check_idle(2, 2);
        send_frame(1, 8'hA3, 1'b0, 0, 0); check_idle(1, 2);

        // Back-to-back with en held, then an ignored pulse during frame 2
        send_frame(0, 8'h11, 1'b1, 0, 0);
        send_frame(0, 8'h22, 1'b0, 30, 0);
        check_idle(0, 30);

        // Reset at cycle 45 of a frame, then a clean frame
        send_frame(0, 8'h00, 1'b0, 0, 45);
        check_idle(0, 3);
        send_frame(0, 8'h3C, 1'b0, 0, 0); check_idle(0, 2);

        // Random words with random gaps (gap 0 gives back-to-back frames)
        for (int i = 0; i < 24; i++) begin
            k = i / 8;
            send_frame(k, 8'($urandom), 1'b0, 0, 0);
            gap = int'($urandom_range(0, 3));
            if (gap > 0) check_idle(k, gap);
        end
        check_idle(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
